// File: rtl/shift_pkg.sv
// Shared defaults, coordinate type and FSM state type for shift_arbiter.
package shift_pkg;

  localparam int unsigned CW_DEFAULT   = 8;
  localparam int unsigned NREQ_DEFAULT = 4;

  typedef logic [CW_DEFAULT-1:0] coord_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_rr_arb.sv
// Round-robin grant: the search begins one past the last winner and wraps.
module shift_rr_arb
  import shift_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_any
);

  localparam int unsigned IW = $clog2(NREQ);

  int unsigned pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = (32'(last) + k) % NREQ;
      if (!grant_any && req[IW'(pos)]) begin
        grant_any          = 1'b1;
        grant[IW'(pos)]    = 1'b1;
        grant_idx          = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates NREQ coordinate requesters into one centre-translating output register.
// Define SHIFT_ARB_SATURATE_EN for signed saturating subtraction instead of wrap.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned CW   = CW_DEFAULT
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    CFG_WE,
  input  logic [CW-1:0]           CFG_XC,
  input  logic [CW-1:0]           CFG_YC,
  input  logic [NREQ-1:0]         REQ_VALID,
  input  logic [NREQ*CW-1:0]      REQ_X,
  input  logic [NREQ*CW-1:0]      REQ_Y,
  output logic [NREQ-1:0]         REQ_READY,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [CW-1:0]           OUT_X,
  output logic [CW-1:0]           OUT_Y,
  output logic [$clog2(NREQ)-1:0] OUT_ID,
  output logic [15:0]             XFER_CNT
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [0:0] ST_EMPTY = EMPTY;
  localparam logic [0:0] ST_FULL  = FULL;

  logic [0:0]      state;
  logic [CW-1:0]   xc, yc;
  logic [IW-1:0]   last;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic            can_accept, req_xfer, out_xfer;
  logic [CW-1:0]   sel_x, sel_y;

  function automatic logic [CW-1:0] shift_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
`ifdef SHIFT_ARB_SATURATE_EN
    logic [CW:0] d;
    // One guard bit: overflow shows as the two top bits disagreeing.
    d = {a[CW-1], a} - {b[CW-1], b};
    if (d[CW] != d[CW-1])
      return d[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    return d[CW-1:0];
`else
    return a - b;
`endif
  endfunction

  shift_rr_arb #(.NREQ(NREQ)) u_arb (
    .req       (REQ_VALID),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    can_accept = ARESETN && ((state == ST_EMPTY) || OUT_READY);
    REQ_READY  = can_accept ? grant : '0;
    req_xfer   = can_accept && grant_any;
    OUT_VALID  = (state == ST_FULL);
    out_xfer   = (state == ST_FULL) && OUT_READY;
    sel_x      = REQ_X[32'(grant_idx)*CW +: CW];
    sel_y      = REQ_Y[32'(grant_idx)*CW +: CW];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= ST_EMPTY;
      OUT_X    <= '0;
      OUT_Y    <= '0;
      OUT_ID   <= '0;
      xc       <= '0;
      yc       <= '0;
      last     <= IW'(NREQ - 1);
      XFER_CNT <= '0;
    end else begin
      if (out_xfer)
        XFER_CNT <= XFER_CNT + 16'd1;
      if (req_xfer) begin
        state  <= ST_FULL;
        OUT_X  <= shift_sub(sel_x, xc);
        OUT_Y  <= shift_sub(sel_y, yc);
        OUT_ID <= grant_idx;
        last   <= grant_idx;
      end else if (out_xfer) begin
        state  <= ST_EMPTY;
      end
      // Capture above sees the old centre; the new one lands this same edge.
      if (CFG_WE) begin
        xc <= CFG_XC;
        yc <= CFG_YC;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vectors plus a per-cycle reference model.
module tb_shift_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        CFG_WE = 1'b0;
  logic [7:0]  CFG_XC = '0, CFG_YC = '0;
  logic [3:0]  REQ_VALID = '0;
  logic [31:0] REQ_X = '0, REQ_Y = '0;
  logic [3:0]  REQ_READY;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [7:0]  OUT_X, OUT_Y;
  logic [1:0]  OUT_ID;
  logic [15:0] XFER_CNT;

  int passed = 0;
  int total  = 0;

  shift_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .CFG_WE(CFG_WE), .CFG_XC(CFG_XC), .CFG_YC(CFG_YC),
    .REQ_VALID(REQ_VALID), .REQ_X(REQ_X), .REQ_Y(REQ_Y), .REQ_READY(REQ_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_X(OUT_X), .OUT_Y(OUT_Y),
    .OUT_ID(OUT_ID), .XFER_CNT(XFER_CNT)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state (integer abstraction of the spec's rules)
  bit m_full = 0;
  int m_x = 0, m_y = 0, m_id = 0, m_last = NREQ - 1, m_xc = 0, m_yc = 0, m_cnt = 0;

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int sub(input int a, input int b);
`ifdef SHIFT_ARB_SATURATE_EN
    int sa, sb, d;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    d  = sa - sb;
    if (d > 127) d = 127;
    if (d < -128) d = -128;
    return d & 255;
`else
    return (a - b) & 255;
`endif
  endfunction

  always @(posedge ACLK or negedge ARESETN) begin
    int g;
    bit take, give;
    if (!ARESETN) begin
      m_full = 0; m_x = 0; m_y = 0; m_id = 0; m_last = NREQ - 1;
      m_xc = 0; m_yc = 0; m_cnt = 0;
    end else begin
      g    = pick(REQ_VALID, m_last);
      take = (!m_full || OUT_READY) && (g >= 0);
      give = m_full && OUT_READY;
      if (give) m_cnt = (m_cnt + 1) % 65536;
      if (take) begin
        m_x = sub(int'(REQ_X[g*CW +: CW]), m_xc);
        m_y = sub(int'(REQ_Y[g*CW +: CW]), m_yc);
        m_id = g; m_last = g; m_full = 1;
      end else if (give) begin
        m_full = 0;
      end
      if (CFG_WE) begin m_xc = int'(CFG_XC); m_yc = int'(CFG_YC); end
    end
  end

  always @(negedge ACLK) begin
    int g;
    logic [3:0] er;
    g  = pick(REQ_VALID, m_last);
    er = (ARESETN && (!m_full || OUT_READY) && g >= 0) ? 4'(1 << g) : 4'b0;
    chk("m_req_ready", int'(REQ_READY), int'(er));
    chk("m_out_valid", int'(OUT_VALID), int'(m_full));
    chk("m_xfer_cnt", int'(XFER_CNT), m_cnt);
    if (m_full || !ARESETN) begin
      chk("m_out_x", int'(OUT_X), m_x);
      chk("m_out_y", int'(OUT_Y), m_y);
      chk("m_out_id", int'(OUT_ID), m_id);
    end
  end

  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  task automatic set_pt(input int i, input int x, input int y);
    REQ_X[i*CW +: CW] = 8'(x);
    REQ_Y[i*CW +: CW] = 8'(y);
  endtask

  task automatic cfg(input int xc, input int yc);
    CFG_WE = 1'b1; CFG_XC = 8'(xc); CFG_YC = 8'(yc);
    step();
    CFG_WE = 1'b0;
  endtask

  initial begin
    // Reset: nothing granted even with every requester asserting
    REQ_VALID = 4'hF;
    step(); step();
    chk("rst_ready", int'(REQ_READY), 0);
    chk("rst_valid", int'(OUT_VALID), 0);
    chk("rst_cnt", int'(XFER_CNT), 0);
    chk("rst_x", int'(OUT_X), 0);
    REQ_VALID = '0;
    ARESETN = 1'b1;

    // Basic translate
    cfg('h10, 'h20);
    set_pt(0, 'h15, 'h25); REQ_VALID = 4'b0001; OUT_READY = 1'b0;
    #1 chk("grant0", int'(REQ_READY), 1);
    step(); REQ_VALID = '0;
    chk("basic_valid", int'(OUT_VALID), 1);
    chk("basic_x", int'(OUT_X), 'h05);
    chk("basic_y", int'(OUT_Y), 'h05);
    chk("basic_id", int'(OUT_ID), 0);
    OUT_READY = 1'b1;
    step();
    chk("basic_cnt", int'(XFER_CNT), 1);
    chk("basic_drain", int'(OUT_VALID), 0);

    // Round-robin with all requesters active
    ARESETN = 1'b0; step(); ARESETN = 1'b1;
    for (int i = 0; i < NREQ; i++) set_pt(i, 'h30 + i, 'h40 + i);
    REQ_VALID = 4'hF; OUT_READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_id", int'(OUT_ID), k % 4);
    end
    REQ_VALID = '0;
    step();
    chk("rr_cnt", int'(XFER_CNT), 8);
    chk("rr_empty", int'(OUT_VALID), 0);

    // Back-pressure hold
    set_pt(1, 'h03, 'h04); REQ_VALID = 4'b0010; OUT_READY = 1'b0;
    step();
    set_pt(1, 'h77, 'h66);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", int'(OUT_VALID), 1);
      chk("hold_x", int'(OUT_X), 'h03);
      chk("hold_y", int'(OUT_Y), 'h04);
      chk("hold_id", int'(OUT_ID), 1);
      chk("hold_ready", int'(REQ_READY), 0);
    end
    REQ_VALID = '0; OUT_READY = 1'b1;
    step();
    chk("hold_cnt", int'(XFER_CNT), 9);
    chk("hold_drain", int'(OUT_VALID), 0);

    // Negative result and overflow boundary
    cfg('h10, 0);
    set_pt(2, 'h05, 0); REQ_VALID = 4'b0100;
    step(); REQ_VALID = '0;
    chk("neg_x", int'(OUT_X), 'hF5);
    cfg('h7F, 0);
    set_pt(2, 'h80, 0); REQ_VALID = 4'b0100;
    step(); REQ_VALID = '0;
`ifdef SHIFT_ARB_SATURATE_EN
    chk("ovf_x", int'(OUT_X), 'h80);
`else
    chk("ovf_x", int'(OUT_X), 'h01);
`endif

    // Centre update coinciding with capture
    cfg('h10, 0);
    set_pt(3, 'h50, 0); REQ_VALID = 4'b1000;
    CFG_WE = 1'b1; CFG_XC = 8'h40; CFG_YC = 8'h00;
    step(); CFG_WE = 1'b0;
    chk("cfg_old_x", int'(OUT_X), 'h40);
    step(); REQ_VALID = '0;
    chk("cfg_new_x", int'(OUT_X), 'h10);

    // Mid-transfer reset
    OUT_READY = 1'b0;
    set_pt(0, 'h09, 'h09); REQ_VALID = 4'b0001;
    step(); REQ_VALID = '0;
    chk("pre_rst_valid", int'(OUT_VALID), 1);
    ARESETN = 1'b0;
    #1;
    chk("async_valid", int'(OUT_VALID), 0);
    chk("async_cnt", int'(XFER_CNT), 0);
    chk("async_x", int'(OUT_X), 0);
    step();
    ARESETN = 1'b1;

    // First edge after reset release accepts a point
    set_pt(0, 'h21, 'h22); REQ_VALID = 4'b0001;
    step(); REQ_VALID = '0;
    chk("first_valid", int'(OUT_VALID), 1);
    chk("first_x", int'(OUT_X), 'h21);
    chk("first_id", int'(OUT_ID), 0);

    // Mixed traffic, checked cycle by cycle against the model
    for (int k = 0; k < 80; k++) begin
      REQ_VALID = 4'($urandom);
      OUT_READY = 1'($urandom);
      CFG_WE    = ($urandom_range(0, 7) == 0);
      CFG_XC    = 8'($urandom);
      CFG_YC    = 8'($urandom);
      REQ_X     = $urandom;
      REQ_Y     = $urandom;
      step();
    end
    REQ_VALID = '0; CFG_WE = 1'b0; OUT_READY = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of coordinate requesters sharing the translate datapath (2..8).
REQ-002 Parameter CW, default 8, coordinate width in bits.
REQ-003 ACLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 CFG_WE  in  1  load center registers this cycle.
REQ-006 CFG_XC, CFG_YC  in  CW each  new X/Y center values.
REQ-007 REQ_VALID  in  NREQ  per-requester point-available flag.
REQ-008 REQ_X, REQ_Y  in  NREQ*CW each  packed per-requester coordinates; requester i occupies bits [i*CW +: CW].
REQ-009 REQ_READY  out  NREQ  per-requester accept; at most one bit high, one-hot.
REQ-010 OUT_VALID  out  1  translated point available.
REQ-011 OUT_READY  in  1  downstream accept.
REQ-012 OUT_X, OUT_Y  out  CW each  translated coordinates.
REQ-013 OUT_ID  out  clog2(NREQ)  index of the originating requester.
REQ-014 XFER_CNT  out  16  count of completed output transfers, wraps at 65535 to 0.

Function
REQ-015 Transfer on requester side: REQ_VALID[i] and REQ_READY[i] both high at a rising edge.
REQ-016 Transfer on output side: OUT_VALID and OUT_READY both high at a rising edge.
REQ-017 FSM states: EMPTY (output register empty) and FULL (output register holds a point).
REQ-018 Transitions: EMPTY->FULL on requester transfer; FULL->EMPTY on output transfer with no requester transfer; FULL->FULL on simultaneous output and requester transfer, or on no transfer.
REQ-019 REQ_READY is combinational: the granted bit is high only when REQ_VALID is high for that requester and (state EMPTY or OUT_READY high).
REQ-020 Grant is round-robin: search starts at (last winner + 1) mod NREQ; the last-winner register updates only on a requester transfer.
REQ-021 Latency: the point captured at edge N is presented at OUT_* from edge N; throughput is one point per cycle while OUT_READY stays high.
REQ-022 OUT_X = REQ_X[i] - XC and OUT_Y = REQ_Y[i] - YC, both modulo 2^CW; OUT_ID = i.
REQ-023 OUT_X, OUT_Y and OUT_ID SHALL hold stable while OUT_VALID is high and OUT_READY is low.
REQ-024 A CFG_WE in the same cycle as a requester transfer: the capture uses the old center, and the new center applies from the next edge.
REQ-025 A requester that drops REQ_VALID before its transfer loses the grant with no state change.
REQ-026 XFER_CNT increments by 1 on each output transfer.

Reset
REQ-027 While ARESETN is low: state EMPTY, OUT_VALID 0, OUT_X/OUT_Y/OUT_ID 0, XC/YC 0, last winner NREQ-1 (so requester 0 is searched first), XFER_CNT 0.
REQ-028 Reset asserted mid-transfer discards the held point, and no REQ_READY is high during reset.
REQ-029 The first requester transfer is possible at the first edge after ARESETN deasserts.

Configuration
REQ-030 Macro SHIFT_ARB_SATURATE_EN defined: subtraction is signed two's-complement, and results clamp to [-2^(CW-1), 2^(CW-1)-1].
REQ-031 Macro SHIFT_ARB_SATURATE_EN undefined: subtraction wraps modulo 2^CW per REQ-022.

Structure
REQ-032 Package shift_pkg holds CW default, NREQ default, the coordinate typedef and the FSM state enum.
REQ-033 Sub-module shift_rr_arb (NREQ-wide round-robin grant from request vector and last winner) is instantiated once.

Verification
REQ-034 Reset, then XC=0x10, YC=0x20 via CFG_WE; requester 0 sends (0x15,0x25) -> next edge OUT_VALID=1, OUT_X=0x05, OUT_Y=0x05, OUT_ID=0.
REQ-035 All 4 REQ_VALID held high and OUT_READY=1 for 8 cycles -> OUT_ID sequence 0,1,2,3,0,1,2,3; XFER_CNT=8.
REQ-036 OUT_READY=0 for 5 cycles with point (0x03,0x04) held -> OUT_* stable, REQ_READY=0, state FULL; OUT_READY=1 -> one transfer.
REQ-037 XC=0x10, requester X=0x05 -> OUT_X=0xF5 without macro; OUT_X=0xF5 (-11) with macro. XC=0x7F, X=0x80 -> 0x01 wrap without macro; 0x80 (-128 clamp) with macro.
REQ-038 CFG_WE (XC=0x40) in the same cycle as capture of X=0x50 with old XC=0x10 -> OUT_X=0x40; the next capture uses 0x40.
REQ-039 ARESETN pulsed low while FULL -> OUT_VALID=0 immediately, and XFER_CNT=0.
